// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS32 controller: state encoding,
// opcode/funct constants, ALU control codes, mux select codes and error codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  // Opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct field, IR[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  // Sticky error codes
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // States in which the controller waits on the memory handshake
  function automatic logic is_mem_wait(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/control_multiciclo_if.sv
// Controller <-> datapath bundle: decoded IR fields, flags, memory handshake
// and every datapath strobe/mux select the controller produces.
interface control_multiciclo_if;
  logic [5:0]  instruccion;
  logic [5:0]  CampoFuncion;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        IorD;
  logic        LeerMem;
  logic        EscrMem;
  logic        ir_write;
  logic        RegDest;
  logic        MemaReg;
  logic        EscrReg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  controldeALU;
  logic [1:0]  error;
  logic [31:0] retired_cnt;

  // The controller side
  modport master (
    input  instruccion, CampoFuncion, zero, mem_ready,
    output pc_write, pc_src, IorD, LeerMem, EscrMem, ir_write, RegDest,
           MemaReg, EscrReg, alu_src_a, alu_src_b, controldeALU, error,
           retired_cnt
  );

  // The datapath side
  modport slave (
    output instruccion, CampoFuncion, zero, mem_ready,
    input  pc_write, pc_src, IorD, LeerMem, EscrMem, ir_write, RegDest,
           MemaReg, EscrReg, alu_src_a, alu_src_b, controldeALU, error,
           retired_cnt
  );
endinterface

// File: rtl/alu_func_dec.sv
// R-type funct decoder: maps funct to an ALU control code and flags whether
// the funct is one the datapath supports.
import mips_ctrl_pkg::*;

module alu_func_dec (
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       funct_valid_o
);

  // Pure lookup; unsupported functs fall back to add and are flagged invalid
  always_comb begin
    alu_ctrl_o    = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  alu_ctrl_o = ALU_ADD;
      FN_SUB:  alu_ctrl_o = ALU_SUB;
      FN_AND:  alu_ctrl_o = ALU_AND;
      FN_OR:   alu_ctrl_o = ALU_OR;
      FN_SLT:  alu_ctrl_o = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_multiciclo.sv
// Multicycle MIPS32 controller: Moore sequencer for fetch/decode/execute with
// a memory-ready handshake, timeout trap and illegal-instruction trap.
// Optional retired-instruction counter enabled by CONTROL_MULTICICLO_PERF_EN.
import mips_ctrl_pkg::*;

module control_multiciclo #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst_n,
  control_multiciclo_if.master bus
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [1:0] err_q, err_d;
  logic [7:0] wait_q, wait_d;

  logic [2:0] fn_alu;
  logic       fn_valid;

  alu_func_dec u_func_dec (
    .funct_i       (bus.CampoFuncion),
    .alu_ctrl_o    (fn_alu),
    .funct_valid_o (fn_valid)
  );

  // Next state, sticky error and memory-wait counter
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (bus.instruccion)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_RTYPE: begin
            if (fn_valid) begin
              state_d = S_EXEC;
            end else begin
              state_d = S_TRAP;
              err_d   = ERR_ILLEGAL;
            end
          end
          default: begin
            state_d = S_TRAP;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_d = (bus.instruccion == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD, S_MEMWR: begin
        if (bus.mem_ready) begin
          state_d = (state_q == S_MEMRD) ? S_MEMWB : S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_MEMWB:  state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase

    // Counter restarts whenever the state changes, so each wait state starts at 0
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (is_mem_wait(state_q) && !bus.mem_ready) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  // State, error and wait counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      err_q   <= ERR_NONE;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  // Datapath strobes and selects decoded from the current state
  always_comb begin
    bus.pc_write     = 1'b0;
    bus.pc_src       = PCSRC_ALU;
    bus.IorD         = 1'b0;
    bus.LeerMem      = 1'b0;
    bus.EscrMem      = 1'b0;
    bus.ir_write     = 1'b0;
    bus.RegDest      = 1'b0;
    bus.MemaReg      = 1'b0;
    bus.EscrReg      = 1'b0;
    bus.alu_src_a    = 1'b0;
    bus.alu_src_b    = SRCB_RT;
    bus.controldeALU = 3'b000;
    case (state_q)
      S_FETCH: begin
        bus.LeerMem      = 1'b1;
        bus.alu_src_b    = SRCB_FOUR;
        bus.controldeALU = ALU_ADD;
        bus.pc_src       = PCSRC_ALU;
        bus.ir_write     = bus.mem_ready;
        bus.pc_write     = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b    = SRCB_IMMSH2;
        bus.controldeALU = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        bus.alu_src_a    = 1'b1;
        bus.alu_src_b    = SRCB_IMM;
        bus.controldeALU = ALU_ADD;
      end
      S_MEMRD: begin
        bus.LeerMem = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.EscrReg = 1'b1;
        bus.MemaReg = 1'b1;
      end
      S_MEMWR: begin
        bus.EscrMem = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_EXEC: begin
        bus.alu_src_a    = 1'b1;
        bus.alu_src_b    = SRCB_RT;
        bus.controldeALU = fn_alu;
      end
      S_ALUWB: begin
        bus.EscrReg = 1'b1;
        bus.RegDest = 1'b1;
      end
      S_ADDIWB: bus.EscrReg = 1'b1;
      S_BRANCH: begin
        bus.alu_src_a    = 1'b1;
        bus.alu_src_b    = SRCB_RT;
        bus.controldeALU = ALU_SUB;
        bus.pc_src       = PCSRC_ALUOUT;
        bus.pc_write     = bus.zero;
      end
      S_JUMP: begin
        bus.pc_src   = PCSRC_JUMP;
        bus.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.error = err_q;

`ifdef CONTROL_MULTICICLO_PERF_EN
  logic [31:0] retired_q;
  logic        retire_now;

  // An instruction retires on its last cycle; traps never count
  always_comb begin
    retire_now = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire_now = 1'b1;
      S_MEMWR: retire_now = bus.mem_ready;
      default: retire_now = 1'b0;
    endcase
  end

  // Free-running retired counter, wraps naturally at 32 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= 32'd0;
    end else if (retire_now) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign bus.retired_cnt = retired_q;
`else
  assign bus.retired_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_control_multiciclo.sv
// Self-checking bench for control_multiciclo. Builds a per-instruction queue of
// expected cycles from the instruction's behaviour and compares every cycle.
// Retired-count checks follow CONTROL_MULTICICLO_PERF_EN.
module tb_control_multiciclo;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

`ifdef CONTROL_MULTICICLO_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    bit          mr;
    logic [17:0] exp;
    bit          last;
  } step_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] modelRet = 32'd0;
  step_t q[$];

  control_multiciclo_if bus();

  control_multiciclo #(.MEM_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {pc_write, pc_src, IorD, LeerMem, EscrMem, ir_write, RegDest, MemaReg,
  //  EscrReg, alu_src_a, alu_src_b, controldeALU, error}
  function automatic logic [17:0] mk(input bit pcw, input logic [1:0] pcs,
      input bit iord, input bit leer, input bit escr, input bit irw,
      input bit rdst, input bit mreg, input bit ereg, input bit sa,
      input logic [1:0] sb, input logic [2:0] alu, input logic [1:0] err);
    return {pcw, pcs, iord, leer, escr, irw, rdst, mreg, ereg, sa, sb, alu, err};
  endfunction

  function automatic logic [17:0] observed();
    return {bus.pc_write, bus.pc_src, bus.IorD, bus.LeerMem, bus.EscrMem,
            bus.ir_write, bus.RegDest, bus.MemaReg, bus.EscrReg, bus.alu_src_a,
            bus.alu_src_b, bus.controldeALU, bus.error};
  endfunction

  function automatic logic [2:0] refAlu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkRetired(input string tag);
    checkOutput(tag, bus.retired_cnt, PERF ? modelRet : 32'd0);
  endtask

  // Drive one cycle's inputs at the falling edge and check just after
  task automatic applyStimulus(input string tag, input bit mr, input logic [17:0] exp);
    bus.mem_ready = mr;
    #1;
    checkOutput(tag, {14'd0, observed()}, {14'd0, exp});
    checkRetired({tag, "_ret"});
    @(negedge clk);
  endtask

  // Assert reset from wherever we are, release, see INIT then land in FETCH
  task automatic doReset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    modelRet = 32'd0;
    checkOutput("reset_outs", {14'd0, observed()}, 32'd0);
    checkRetired("reset_ret");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("init", 1'b1, 18'd0);
  endtask

  // Run one legal instruction starting in FETCH with the given memory delays
  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn,
      input int fd, input int md, input bit z, input string tag);
    logic [17:0] fw, fr;
    fw = mk(0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00);
    fr = mk(1, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00);
    q.delete();
    for (int i = 0; i < fd; i++) q.push_back('{1'b0, fw, 1'b0});
    q.push_back('{1'b1, fr, 1'b0});
    q.push_back('{1'($urandom), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 0), 1'b0});
    case (op)
      OP_LW: begin
        q.push_back('{1'($urandom), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 0), 1'b0});
        for (int i = 0; i < md; i++) q.push_back('{1'b0, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0});
        q.push_back('{1'b1, mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0});
        q.push_back('{1'($urandom), mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0), 1'b1});
      end
      OP_SW: begin
        q.push_back('{1'($urandom), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 0), 1'b0});
        for (int i = 0; i < md; i++) q.push_back('{1'b0, mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0});
        q.push_back('{1'b1, mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1});
      end
      OP_RTYPE: begin
        q.push_back('{1'($urandom), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, refAlu(fn), 0), 1'b0});
        q.push_back('{1'($urandom), mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 1'b1});
      end
      OP_ADDI: begin
        q.push_back('{1'($urandom), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 0), 1'b0});
        q.push_back('{1'($urandom), mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 1'b1});
      end
      OP_BEQ:
        q.push_back('{1'($urandom), mk(z, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 0), 1'b1});
      default:
        q.push_back('{1'($urandom), mk(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1});
    endcase
    bus.instruccion  = op;
    bus.CampoFuncion = fn;
    bus.zero         = z;
    foreach (q[i]) begin
      applyStimulus($sformatf("%s_c%0d", tag, i), q[i].mr, q[i].exp);
      if (q[i].last) modelRet = modelRet + 32'd1;
    end
  endtask

  // Illegal instruction: fetch, decode, then a held trap with error=01
  task automatic runIllegal(input logic [5:0] op, input logic [5:0] fn, input string tag);
    bus.instruccion  = op;
    bus.CampoFuncion = fn;
    applyStimulus({tag, "_fetch"}, 1'b1, mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 0));
    applyStimulus({tag, "_decode"}, 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 0));
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("%s_trap%0d", tag, i), 1'($urandom), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01));
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    bus.instruccion = 6'd0;
    bus.CampoFuncion = 6'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    doReset();

    $display("[TB] lw with 3-cycle waits, beq taken/not taken, R-type sub");
    runInstr(OP_LW, 6'd0, 3, 3, 1'b0, "lw33");
    runInstr(OP_BEQ, 6'd0, 0, 0, 1'b1, "beq_z1");
    runInstr(OP_BEQ, 6'd0, 0, 0, 1'b0, "beq_z0");
    runInstr(OP_RTYPE, 6'b100010, 1, 0, 1'b0, "sub");

    $display("[TB] reset in the middle of an lw");
    bus.instruccion = OP_LW;
    applyStimulus("abort_fetch", 1'b1, mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 0));
    applyStimulus("abort_decode", 1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 0));
    doReset();

    $display("[TB] illegal opcode and illegal funct");
    runIllegal(6'b111111, 6'b100000, "badop");
    doReset();
    runIllegal(OP_RTYPE, 6'b000111, "badfn");
    doReset();

    $display("[TB] fetch timeout after 16 cycles");
    bus.instruccion = OP_J;
    for (int i = 0; i < 16; i++)
      applyStimulus($sformatf("to_fetch%0d", i), 1'b0, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 0));
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("to_trap%0d", i), 1'($urandom), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10));
    doReset();
    runInstr(OP_J, 6'd0, 15, 0, 1'b0, "ready16");

    $display("[TB] retired count over lw, sw, addi, j, beq");
    doReset();
    runInstr(OP_LW, 6'd0, 0, 1, 1'b0, "p_lw");
    runInstr(OP_SW, 6'd0, 1, 2, 1'b0, "p_sw");
    runInstr(OP_ADDI, 6'd0, 0, 0, 1'b0, "p_addi");
    runInstr(OP_J, 6'd0, 0, 0, 1'b0, "p_j");
    runInstr(OP_BEQ, 6'd0, 0, 0, 1'b1, "p_beq");
    #1;
    checkOutput("retired_five", bus.retired_cnt, PERF ? 32'd5 : 32'd0);
    @(negedge clk);
`ifdef CONTROL_MULTICICLO_PERF_EN
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    modelRet = 32'hFFFF_FFFF;
    runInstr(OP_J, 6'd0, 0, 0, 1'b0, "wrap");
    #1;
    checkOutput("retired_wrap", bus.retired_cnt, 32'd0);
    @(negedge clk);
`endif

    $display("[TB] randomized instruction mix");
    for (int n = 0; n < 30; n++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 5)];
      fn = (op == OP_RTYPE) ? fns[$urandom_range(0, 4)] : 6'($urandom);
      runInstr(op, fn, $urandom_range(0, 4), $urandom_range(0, 4),
               1'($urandom), $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
Moore FSM that sequences a multicycle MIPS32 datapath: shared memory port, IR, register file, ALU, PC. Decodes opcode/funct, drives all datapath strobes and muxes, resolves branches from zero, and stalls on a memory ready handshake. Replaces the single-cycle combinational control chain (main control, ALU control, PC source) with one sequenced controller.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory state waits for mem_ready before trapping (range 2..255).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instruccion  in  6  opcode, IR[31:26]
CampoFuncion  in  6  funct, IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle
pc_write  out  1  PC load strobe
pc_src  out  2  00 ALU result (PC+4), 01 ALUOut (branch target), 10 jump target
IorD  out  1  memory address: 0 PC, 1 ALUOut
LeerMem  out  1  memory read request
EscrMem  out  1  memory write request
ir_write  out  1  IR load strobe
RegDest  out  1  write register: 0 rt, 1 rd
MemaReg  out  1  write-back data: 0 ALUOut, 1 MDR
EscrReg  out  1  register-file write strobe
alu_src_a  out  1  0 PC, 1 rs
alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
controldeALU  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
error  out  2  00 none, 01 illegal instruction, 10 memory timeout; sticky
retired_cnt  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Supported: R-type 000000 (funct add 100000, sub 100010, and 100100, or 100101, slt 101010), lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- States: INIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, ADDIEX, ADDIWB, TRAP. 4-bit encoding.
- Reset: state=INIT, error=00, wait counter=0. In INIT every output is 0. INIT→FETCH unconditionally next cycle. rst_n low mid-instruction aborts to INIT immediately, with no strobe asserted after the asserting edge.
- Outputs are pure decode of state plus zero/mem_ready. Only the listed strobes may be 1; all others are 0.
- FETCH: LeerMem=1, IorD=0, alu_src_a=0, alu_src_b=01, add, pc_src=00. While mem_ready=0, stay in FETCH. When mem_ready=1: ir_write=1, pc_write=1, →DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target precomputed).
  - lw/sw →MEMADR; R-type with supported funct →EXEC; beq →BRANCH; j →JUMP; addi →ADDIEX.
  - Anything else →TRAP with error=01.
- MEMADR: alu_src_a=1, alu_src_b=10, add. lw →MEMRD, sw →MEMWR.
- MEMRD: LeerMem=1, IorD=1; wait for mem_ready, then →MEMWB.
- MEMWB: EscrReg=1, RegDest=0, MemaReg=1; →FETCH.
- MEMWR: EscrMem=1, IorD=1; wait for mem_ready, then →FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, controldeALU from funct; →ALUWB.
- ALUWB: EscrReg=1, RegDest=1, MemaReg=0; →FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add; →ADDIWB.
- ADDIWB: EscrReg=1, RegDest=0, MemaReg=0; →FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_write=zero; →FETCH.
- JUMP: pc_src=10, pc_write=1; →FETCH.
- Memory wait:
  - An 8-bit counter clears on entry to FETCH, MEMRD or MEMWR and increments each cycle with mem_ready=0.
  - When the counter reaches MEM_TIMEOUT-1 with mem_ready still 0: →TRAP, error=10. mem_ready=1 on that same cycle wins (no trap).
- TRAP: all outputs 0 except error; held until reset.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR.

Optional Feature:
- Macro: CONTROL_MULTICICLO_PERF_EN.
- With the macro: retired_cnt resets to 0 and increments by 1 on each instruction's final cycle: MEMWB, MEMWR&mem_ready, ALUWB, ADDIWB, BRANCH, JUMP. It wraps 0xFFFFFFFF→0. It does not count in TRAP.
- Without the macro: retired_cnt tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - funct constants;
  - ALU control codes (ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111);
  - pc_src and alu_src_b codes;
  - error codes.
- One sub-module, alu_func_dec: combinational funct→{controldeALU, funct_valid}. Used in both EXEC and DECODE legality checks.

Test Plan:
- Reset/INIT: hold rst_n=0 then release → one INIT cycle with all outputs 0, then FETCH with LeerMem=1.
- lw with mem_ready delayed 3 cycles in both FETCH and MEMRD:
  - ir_write=1 and pc_write=1 only on the ready cycle;
  - EscrReg=1 with MemaReg=1 in MEMWB;
  - 5 states plus 6 wait cycles in total.
- beq twice:
  - zero=1 → pc_write=1 with pc_src=01 in BRANCH;
  - zero=0 → pc_write=0; FETCH follows in both cases.
- R-type funct 100010 → controldeALU=110 in EXEC, EscrReg=1 with RegDest=1 in ALUWB. Opcode 111111 and R-type funct 000111 → TRAP, error=01, outputs 0 until reset.
- MEM_TIMEOUT=16, mem_ready held 0 in FETCH:
  - TRAP, error=10 after 16 FETCH cycles;
  - repeat with mem_ready=1 on the 16th cycle → no trap.
- With CONTROL_MULTICICLO_PERF_EN: lw, sw, addi, j, beq in sequence → retired_cnt=5. Preload 0xFFFFFFFF via force → wraps to 0. Without the macro, retired_cnt stays 0.
